// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush scheduler.
// Bus bit order: 4 = PC, 3 = IF/ID, 2 = ID/EX, 1 = EX/MEM, 0 = MEM/WB.
package pipe_ctrl_pkg;
  localparam int HB_W     = 5;
  localparam int HB_PC    = 4;
  localparam int HB_IFID  = 3;
  localparam int HB_IDEX  = 2;
  localparam int HB_EXMEM = 1;
  localparam int HB_MEMWB = 0;

  typedef logic [HB_W-1:0] hold_bus_t;
  typedef logic [HB_W-1:0] flush_bus_t;

  typedef enum logic {M_IDLE = 1'b0, M_WAIT = 1'b1} mem_state_t;
  typedef enum logic {D_IDLE = 1'b0, D_BUSY = 1'b1} div_state_t;

  localparam hold_bus_t  HOLD_MEM  = 5'b11110;
  localparam hold_bus_t  HOLD_DIV  = 5'b11100;
  localparam hold_bus_t  HOLD_LU   = 5'b11000;
  localparam flush_bus_t FLUSH_MEM = 5'b00001;
  localparam flush_bus_t FLUSH_JMP = 5'b01110;
  localparam flush_bus_t FLUSH_DIV = 5'b00010;
  localparam flush_bus_t FLUSH_LU  = 5'b00100;
endpackage

// File: rtl/pipe_ctrl_mem_fsm.sv
// Data-memory handshake tracker: counts wait cycles for dmem_ack and
// aborts the access with a bus error once MEM_TIMEOUT cycles have elapsed.
module pipe_ctrl_mem_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_access,
  input  logic i_ack,
  output logic o_stall,
  output logic o_bus_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  mem_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;

  assign w_timeout = (r_state == M_WAIT) && (r_cnt == CW'(MEM_TIMEOUT));
  assign o_stall   = i_access && !i_ack && !w_timeout;
  assign o_bus_err = i_access && !i_ack && w_timeout;

  // Any non-stalling cycle (ack, timeout or dropped access) ends the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= M_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        M_IDLE: if (o_stall) begin
          r_state <= M_WAIT;
          r_cnt   <= CW'(1);
        end
        M_WAIT: if (!o_stall) begin
          r_state <= M_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Central hold/flush scheduler for the five-stage core: memory wait,
// jump redirect, multi-cycle divide and load-use stalls in priority order.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_rmem,
  input  logic              MEM_wmem,
  input  logic              MEM_jump,
  input  logic [XLEN-1:0]   MEM_jump_addr,
  input  logic              EX_rmem,
  input  logic              EX_wen,
  input  logic [REG_AW-1:0] EX_rd_addr,
  input  logic [REG_AW-1:0] ID_rs1_addr,
  input  logic [REG_AW-1:0] ID_rs2_addr,
  input  logic              ID_rs1_en,
  input  logic              ID_rs2_en,
  input  logic              EX_div_req,
  input  logic              div_done,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              div_start,
  output logic              div_kill,
  output logic [4:0]        hold,
  output logic [4:0]        flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_addr,
  output logic              bus_err,
  output logic [31:0]       stall_cnt
);
  logic       w_access, w_mem_stall, w_bus_err;
  logic       w_jmp, w_busy_done, w_div_stall, w_lu;
  logic       w_div_start, w_div_kill;
  hold_bus_t  w_hold;
  flush_bus_t w_flush;

  div_state_t r_dstate;
  logic       r_done_seen;
  logic [31:0] r_stall_cnt;

  assign w_access = MEM_rmem | MEM_wmem;

  pipe_ctrl_mem_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_access  (w_access),
    .i_ack     (dmem_ack),
    .o_stall   (w_mem_stall),
    .o_bus_err (w_bus_err)
  );

  // A jump held behind a memory stall is re-presented, so only act once MEM moves.
  assign w_jmp       = MEM_jump & ~w_mem_stall;
  assign w_busy_done = (r_dstate == D_BUSY) & div_done;
  assign w_div_stall = EX_div_req & ~r_done_seen & ~w_busy_done;
  assign w_div_start = (r_dstate == D_IDLE) & EX_div_req & ~r_done_seen & ~w_jmp;
  assign w_div_kill  = (r_dstate == D_BUSY) & w_jmp;
  assign w_lu = EX_rmem & EX_wen & (EX_rd_addr != '0) &
                ((ID_rs1_en & (ID_rs1_addr == EX_rd_addr)) |
                 (ID_rs2_en & (ID_rs2_addr == EX_rd_addr)));

  always_comb begin
    w_hold  = '0;
    w_flush = '0;
    if (w_mem_stall) begin
      w_hold  = HOLD_MEM;
      w_flush = FLUSH_MEM;
    end else if (w_jmp) begin
      w_flush = FLUSH_JMP;
    end else if (w_div_stall) begin
      w_hold  = HOLD_DIV;
      w_flush = FLUSH_DIV;
    end else if (w_lu) begin
      w_hold  = HOLD_LU;
      w_flush = FLUSH_LU;
    end
  end

  // done_seen remembers a result consumed while the div sat held in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dstate    <= D_IDLE;
      r_done_seen <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_dstate)
        D_IDLE:  if (w_div_start) r_dstate <= D_BUSY;
        D_BUSY:  if (w_jmp || div_done) r_dstate <= D_IDLE;
        default: r_dstate <= D_IDLE;
      endcase
      r_done_seen <= w_hold[HB_IDEX] ? (r_done_seen | w_busy_done) : 1'b0;
      if ((w_hold != '0) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign dmem_req       = ~rst & w_access;
  assign div_start      = ~rst & w_div_start;
  assign div_kill       = ~rst & w_div_kill;
  assign hold           = rst ? '0 : w_hold;
  assign flush          = rst ? '0 : w_flush;
  assign redirect_valid = ~rst & w_jmp;
  assign redirect_addr  = (rst || !w_jmp) ? '0 : MEM_jump_addr;
  assign bus_err        = ~rst & w_bus_err;
  assign stall_cnt      = rst ? '0 : r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a behavioural model of the scheduler's stall/flush rules.
module tb_pipe_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int MT   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            MEM_rmem, MEM_wmem, MEM_jump;
  logic [XLEN-1:0] MEM_jump_addr;
  logic            EX_rmem, EX_wen;
  logic [AW-1:0]   EX_rd_addr, ID_rs1_addr, ID_rs2_addr;
  logic            ID_rs1_en, ID_rs2_en, EX_div_req, div_done, dmem_ack;
  logic            dmem_req, div_start, div_kill, redirect_valid, bus_err;
  logic [4:0]      hold, flush;
  logic [XLEN-1:0] redirect_addr;
  logic [31:0]     stall_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  pipe_ctrl #(.XLEN(XLEN), .REG_AW(AW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .MEM_rmem(MEM_rmem), .MEM_wmem(MEM_wmem), .MEM_jump(MEM_jump),
    .MEM_jump_addr(MEM_jump_addr), .EX_rmem(EX_rmem), .EX_wen(EX_wen),
    .EX_rd_addr(EX_rd_addr), .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_en(ID_rs1_en), .ID_rs2_en(ID_rs2_en), .EX_div_req(EX_div_req),
    .div_done(div_done), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .div_start(div_start), .div_kill(div_kill), .hold(hold), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model state: cycles already waited on the current access, whether a
  // divide is in flight, whether its result was consumed while EX was held.
  int              m_waited;
  bit              m_busy, m_seen, m_ms, m_jm;
  longint unsigned m_scnt;
  logic            e_req, e_start, e_kill, e_rv, e_berr;
  logic [4:0]      e_hold, e_flush;
  logic [XLEN-1:0] e_ra;
  logic [31:0]     e_scnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit acc, to, ds, lu;
    acc  = MEM_rmem || MEM_wmem;
    to   = (m_waited == MT);
    m_ms = acc && !dmem_ack && !to;
    m_jm = MEM_jump && !m_ms;
    ds   = EX_div_req && !m_seen && !(m_busy && div_done);
    lu   = EX_rmem && EX_wen && (EX_rd_addr != 0) &&
           ((ID_rs1_en && ID_rs1_addr == EX_rd_addr) ||
            (ID_rs2_en && ID_rs2_addr == EX_rd_addr));
    e_hold = 5'b0; e_flush = 5'b0; e_rv = 1'b0; e_ra = '0;
    if (m_ms)      begin e_hold = 5'b11110; e_flush = 5'b00001; end
    else if (m_jm) begin e_flush = 5'b01110; e_rv = 1'b1; e_ra = MEM_jump_addr; end
    else if (ds)   begin e_hold = 5'b11100; e_flush = 5'b00010; end
    else if (lu)   begin e_hold = 5'b11000; e_flush = 5'b00100; end
    e_req   = acc;
    e_start = !m_busy && EX_div_req && !m_seen && !m_jm;
    e_kill  = m_jm && m_busy;
    e_berr  = acc && !dmem_ack && to;
    e_scnt  = m_scnt[31:0];
    if (rst) begin
      e_hold = 5'b0; e_flush = 5'b0; e_rv = 1'b0; e_ra = '0;
      e_req = 1'b0; e_start = 1'b0; e_kill = 1'b0; e_berr = 1'b0; e_scnt = '0;
    end
  endtask

  task automatic model_step();
    bit done_now;
    if (rst) begin
      m_waited = 0; m_busy = 1'b0; m_seen = 1'b0; m_scnt = 0;
    end else begin
      if (e_hold != 5'b0 && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      done_now = m_busy && div_done;
      m_seen   = e_hold[2] ? (m_seen || done_now) : 1'b0;
      if (m_jm || done_now) m_busy = 1'b0;
      else if (e_start)     m_busy = 1'b1;
      m_waited = m_ms ? m_waited + 1 : 0;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
    chk("dmem_req",       dmem_req,       e_req);
    chk("div_start",      div_start,      e_start);
    chk("div_kill",       div_kill,       e_kill);
    chk("hold",           hold,           e_hold);
    chk("flush",          flush,          e_flush);
    chk("redirect_valid", redirect_valid, e_rv);
    chk("redirect_addr",  redirect_addr,  e_ra);
    chk("bus_err",        bus_err,        e_berr);
    chk("stall_cnt",      stall_cnt,      e_scnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    MEM_rmem = 0; MEM_wmem = 0; MEM_jump = 0; MEM_jump_addr = '0;
    EX_rmem = 0; EX_wen = 0; EX_rd_addr = '0; ID_rs1_addr = '0; ID_rs2_addr = '0;
    ID_rs1_en = 0; ID_rs2_en = 0; EX_div_req = 0; div_done = 0; dmem_ack = 0;
  endtask

  initial begin
    m_waited = 0; m_busy = 0; m_seen = 0; m_scnt = 0;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    settle(); chk("rst_hold", hold, 5'b0); chk("rst_cnt", stall_cnt, 32'd0); tick();
    settle(); tick();
    rst = 1'b0;

    // Load with ack three cycles late
    MEM_rmem = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("ld_hold", hold, 5'b11110); chk("ld_flush", flush, 5'b00001); tick();
    end
    dmem_ack = 1;
    settle(); chk("ld_ack_hold", hold, 5'b0); tick();
    MEM_rmem = 0; dmem_ack = 0;
    settle(); chk("ld_cnt", stall_cnt, 32'd3); tick();

    // Jump resolved in MEM
    MEM_jump = 1; MEM_jump_addr = 32'h8000_0040;
    settle();
    chk("jmp_flush", flush, 5'b01110); chk("jmp_rv", redirect_valid, 1'b1);
    chk("jmp_addr", redirect_addr, 32'h8000_0040); chk("jmp_hold", hold, 5'b0);
    tick();
    MEM_jump = 0; MEM_jump_addr = '0;
    settle(); chk("jmp_rv_off", redirect_valid, 1'b0); tick();

    // Divide with done 33 cycles after start
    EX_div_req = 1;
    settle(); chk("div_start0", div_start, 1'b1); chk("div_hold0", hold, 5'b11100); tick();
    for (int i = 1; i < 33; i++) begin
      settle(); chk("div_start_n", div_start, 1'b0); chk("div_hold_n", hold, 5'b11100); tick();
    end
    div_done = 1;
    settle(); chk("div_rel", hold, 5'b0); tick();
    EX_div_req = 0; div_done = 0;
    settle(); chk("div_cnt", stall_cnt, 32'd36); tick();

    // Load-use on rs2, then rd = x0
    EX_rmem = 1; EX_wen = 1; EX_rd_addr = 5'd5; ID_rs2_addr = 5'd5; ID_rs2_en = 1;
    settle(); chk("lu_hold", hold, 5'b11000); chk("lu_flush", flush, 5'b00100); tick();
    EX_rd_addr = 5'd0; ID_rs2_addr = 5'd0;
    settle(); chk("lu_x0", hold, 5'b0); tick();
    idle_inputs();

    // Jump while the divider is busy
    EX_div_req = 1;
    settle(); tick();
    settle(); tick();
    MEM_jump = 1; MEM_jump_addr = 32'h0000_1230;
    settle(); chk("kill", div_kill, 1'b1); chk("kill_rv", redirect_valid, 1'b1);
    chk("kill_nostart", div_start, 1'b0); tick();
    MEM_jump = 0; MEM_jump_addr = '0;
    settle(); chk("kill_idle", div_start, 1'b1); tick();
    EX_div_req = 0; div_done = 1;
    settle(); tick();
    div_done = 0;

    // Store timeout
    MEM_wmem = 1;
    for (int i = 0; i < MT; i++) begin
      settle(); chk("to_hold", hold, 5'b11110); chk("to_noerr", bus_err, 1'b0); tick();
    end
    settle(); chk("to_err", bus_err, 1'b1); chk("to_rel", hold, 5'b0); tick();
    MEM_wmem = 0;
    settle(); chk("to_pulse", bus_err, 1'b0); tick();

    // Reset mid-wait
    MEM_rmem = 1;
    settle(); tick();
    settle(); tick();
    rst = 1;
    settle(); chk("rst_req", dmem_req, 1'b0); chk("rst_hold2", hold, 5'b0); tick();
    rst = 0; MEM_rmem = 0;
    settle(); chk("rst_cnt2", stall_cnt, 32'd0); tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      MEM_rmem      = ($urandom_range(0, 3) == 0);
      MEM_wmem      = ($urandom_range(0, 5) == 0);
      dmem_ack      = $urandom_range(0, 1);
      MEM_jump      = ($urandom_range(0, 7) == 0);
      MEM_jump_addr = $urandom;
      EX_rmem       = ($urandom_range(0, 2) == 0);
      EX_wen        = $urandom_range(0, 1);
      EX_rd_addr    = AW'($urandom_range(0, 3));
      ID_rs1_addr   = AW'($urandom_range(0, 3));
      ID_rs2_addr   = AW'($urandom_range(0, 3));
      ID_rs1_en     = $urandom_range(0, 1);
      ID_rs2_en     = $urandom_range(0, 1);
      EX_div_req    = ($urandom_range(0, 3) == 0);
      div_done      = ($urandom_range(0, 5) == 0);
      settle(); tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hold/flush scheduler for the five-stage core.
- Drives the per-register hold and flush buses consumed by every pipeline register, including EX/MEM at bit 1.
- Sequences the data-memory handshake and the multi-cycle divider; detects load-use hazards; issues the PC redirect for jumps resolved in MEM.
- Sits beside the datapath; contains no datapath registers of its own.

Parameters:
- XLEN, 32, register/address width (`Regnum).
- REG_AW, 5, register-index width (`RegAddrnum).
- MEM_TIMEOUT, 255, maximum wait cycles for dmem_ack before abort; at least 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- MEM_rmem  in  1  load in MEM.
- MEM_wmem  in  1  store in MEM.
- MEM_jump  in  1  taken jump/branch resolved in MEM.
- MEM_jump_addr  in  XLEN  jump target.
- EX_rmem  in  1  load in EX.
- EX_wen  in  1  EX writes rd.
- EX_rd_addr  in  REG_AW  EX destination register.
- ID_rs1_addr, ID_rs2_addr  in  REG_AW each  ID source registers.
- ID_rs1_en, ID_rs2_en  in  1 each  source is actually read.
- EX_div_req  in  1  div/rem instruction in EX.
- div_done  in  1  divider result valid (one-cycle pulse).
- dmem_ack  in  1  data memory completes access.
- dmem_req  out  1  data memory request.
- div_start  out  1  divider start pulse.
- div_kill  out  1  abort divider.
- hold  out  5  `Hold_Bus. Bit 4 = PC, 3 = IF/ID, 2 = ID/EX, 1 = EX/MEM, 0 = MEM/WB.
- flush  out  5  `Flush_Bus, same indexing; bit 4 is always 0.
- redirect_valid  out  1  load PC with redirect_addr.
- redirect_addr  out  XLEN  new PC.
- bus_err  out  1  one-cycle pulse on dmem timeout.
- stall_cnt  out  32  saturating count of cycles with any hold bit set.

Behaviour:
- Reset (rst high at a clock edge):
  - Both FSMs go to IDLE; wait counter = 0; stall_cnt = 0.
  - While rst is high, every output is forced to 0.
- Memory FSM (M_IDLE, M_WAIT):
  - dmem_req = (MEM_rmem | MEM_wmem) in both states.
  - M_IDLE, access present and no dmem_ack: go to M_WAIT with wait counter = 1.
  - M_IDLE, access present with ack in the same cycle: zero-stall; stay in M_IDLE.
  - M_WAIT, ack: go to M_IDLE.
  - M_WAIT, no ack and counter == MEM_TIMEOUT: pulse bus_err, go to M_IDLE, and treat the access as complete (no stall that cycle).
  - M_WAIT otherwise: counter increments.
  - mem_stall = access present, no ack, timeout not reached.
- Divider FSM (D_IDLE, D_BUSY):
  - D_IDLE with EX_div_req and no kill: div_start = 1 for one cycle; go to D_BUSY.
  - D_BUSY, div_done: go to D_IDLE. div_done is expected only in D_BUSY; a div_done in D_IDLE is ignored.
  - div_stall = EX_div_req & !(D_BUSY & div_done).
- Load-use:
  - lu = EX_rmem & EX_wen & EX_rd_addr != 0 & ((ID_rs1_en & rs1 == rd) | (ID_rs2_en & rs2 == rd)).
- Output priority, highest first; all outputs combinational from state and inputs:
  1. mem_stall: hold = 5'b11110, flush = 5'b00001.
  2. MEM_jump: flush = 5'b01110, hold = 0, redirect_valid = 1, redirect_addr = MEM_jump_addr. div_kill = 1 if D_BUSY, and D goes to D_IDLE. div_start is suppressed.
  3. div_stall: hold = 5'b11100, flush = 5'b00010.
  4. lu: hold = 5'b11000, flush = 5'b00100.
  5. Otherwise: hold = 0, flush = 0.
- Interaction rules:
  - Jump during mem_stall is deferred, not lost: MEM is held, so MEM_jump is re-presented.
  - Load-use and divider stall never both apply: the EX instruction is either a load or a div.
  - A div whose div_done arrives while a mem_stall holds EX/MEM is consumed. The FSM returns to D_IDLE, and the held EX_div_req must not restart the divider. Track this with a done_seen flag, cleared when ID/EX advances.
- stall_cnt increments when hold != 0 and saturates at all-ones.

Decomposition:
- Shared package/defines:
  - `Hold_Bus and `Flush_Bus set to [4:0].
  - Stage bit indices HB_PC = 4, HB_IFID = 3, HB_IDEX = 2, HB_EXMEM = 1, HB_MEMWB = 0.
  - FSM state encodings.
- One natural sub-module: pipe_ctrl_mem_fsm, containing the memory FSM plus timeout counter.
- The divider FSM and priority logic stay inline.

Test Plan:
- Load with dmem_ack 3 cycles late -> hold = 11110 and flush = 00001 for exactly 3 cycles, then 0; stall_cnt = 3.
- MEM_jump with target 0x80000040, no stalls -> flush = 01110, redirect_valid = 1, redirect_addr = 0x80000040 for one cycle; hold = 0.
- EX_div_req, div_done 33 cycles after div_start -> single div_start pulse; hold = 11100 for 33 cycles, released in the div_done cycle.
- Load to x5 in EX, ID reads rs2 = x5 with rs2_en -> hold = 11000, flush = 00100 for one cycle. Repeat with rd = x0 -> no stall.
- MEM_jump while D_BUSY -> div_kill = 1, redirect issued, D_IDLE next cycle. Store with no ack and MEM_TIMEOUT = 4 -> bus_err pulse on the 4th wait cycle.
- rst asserted mid-M_WAIT -> all outputs 0, FSMs idle, stall_cnt = 0 on the next cycle.
